// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch controller: next-PC op codes, FSM state
// encodings (also exported on state_dbg) and the idle instruction value.
package fetch_pkg;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JAL    = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_WAIT  = 2'b01,
        S_HOLD  = 2'b10,
        S_HALT  = 2'b11
    } fetch_state_e;

    // Any non-PLUS4 op with redirect_valid is a redirect; undefined ops behave as JALR.
    function automatic logic is_redirect(input logic valid, input logic [2:0] op);
        return valid && (op != NPC_PLUS4);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory and decode-side signals of the fetch controller.
// Handshakes: imem_req/imem_addr hold until imem_gnt (one request in flight);
// if_valid/if_pc/if_inst hold until if_valid & if_ready on a rising edge.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_inst,
        input  imem_gnt, imem_rvalid, imem_rdata, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_inst,
        output imem_gnt, imem_rvalid, imem_rdata, if_ready
    );
endinterface

// File: rtl/fetch_hold_buf.sv
// Holding register for one fetched instruction and its PC; load wins over clear.
module fetch_hold_buf
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_INST = NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst
);

    // pc/inst keep their last contents when cleared; only reset restores them.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= 32'h0000_0000;
            inst  <= RESET_INST;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch PC sequencer: one outstanding imem request, single-entry hold buffer
// toward decode, redirect flush with response dropping, sticky misalign halt.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus,
    output logic [31:0]  npc_pc,
    input  logic [2:0]   npc_op,
    input  logic [31:0]  npc_target,
    input  logic         redirect_valid,
    output logic         misalign_fault,
    output logic [1:0]   state_dbg
);
    import fetch_pkg::*;

    fetch_state_e state, state_nx;
    logic [31:0]  fetch_pc, pc_nx;
    logic         drop, drop_nx;
    logic         fault, fault_nx;
    logic         req;
    logic         buf_load, buf_clear;
    logic         redir, aligned;
    logic         buf_valid;
    logic [31:0]  buf_pc, buf_inst;

    assign redir   = is_redirect(redirect_valid, npc_op);
    assign aligned = (npc_target[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            fetch_pc <= RESET_PC;
            drop     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nx;
            fetch_pc <= pc_nx;
            drop     <= drop_nx;
            fault    <= fault_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = fetch_pc;
        drop_nx   = drop;
        fault_nx  = fault;
        req       = 1'b0;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        case (state)
            S_FETCH: begin
                req = 1'b1;
                if (redir && !aligned) begin
                    // A granted request must still be drained before halting.
                    fault_nx = 1'b1;
                    drop_nx  = bus.imem_gnt;
                    state_nx = bus.imem_gnt ? S_WAIT : S_HALT;
                end else if (redir) begin
                    pc_nx = npc_target;
                    if (bus.imem_gnt) begin
                        drop_nx  = 1'b1;
                        state_nx = S_WAIT;
                    end
                end else if (bus.imem_gnt) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redir) begin
                    if (aligned) pc_nx = npc_target;
                    else         fault_nx = 1'b1;
                end
                if (bus.imem_rvalid) begin
                    if (drop || redir) begin
                        drop_nx  = 1'b0;
                        state_nx = fault_nx ? S_HALT : S_FETCH;
                    end else begin
                        buf_load = 1'b1;
                        state_nx = S_HOLD;
                    end
                end else if (redir) begin
                    drop_nx = 1'b1;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    buf_clear = 1'b1;
                    if (aligned) begin
                        pc_nx    = npc_target;
                        state_nx = S_FETCH;
                    end else begin
                        fault_nx = 1'b1;
                        state_nx = S_HALT;
                    end
                end else if (bus.if_ready) begin
                    buf_clear = 1'b1;
                    pc_nx     = fetch_pc + 32'd4;
                    state_nx  = S_FETCH;
                end
            end
            S_HALT: begin
                state_nx = S_HALT;
            end
            default: begin
                state_nx = S_FETCH;
            end
        endcase
    end

    fetch_hold_buf #(
        .RESET_INST (NOP_INST)
    ) u_hold_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_pc   (fetch_pc),
        .load_inst (bus.imem_rdata),
        .valid     (buf_valid),
        .pc        (buf_pc),
        .inst      (buf_inst)
    );

    assign bus.imem_req   = req & ~rst;
    assign bus.imem_addr  = fetch_pc;
    assign bus.if_valid   = buf_valid;
    assign bus.if_pc      = buf_pc;
    assign bus.if_inst    = buf_inst;
    assign npc_pc         = fetch_pc;
    assign misalign_fault = fault;
    assign state_dbg      = state;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
PC sequencer and instruction-fetch controller for the RV32 core. It owns the architectural fetch PC and drives the PC input of the next-PC unit. It accepts the next-PC unit's redirect target and operation code, and runs a single-outstanding request/grant/response handshake to instruction memory. Fetched instructions go to decode over a valid/ready interface, with stall and redirect-flush handling.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset.
NOP_INST, 32'h0000_0013, value of if_inst when no instruction is held (addi x0,x0,0).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
npc_pc  out  32  current fetch PC, fed to the next-PC unit PC input
npc_op  in  3  next-PC op: 000 PLUS4, 001 BRANCH, 010 JAL, 100 JALR
npc_target  in  32  next-PC unit result
redirect_valid  in  1  EX stage resolved a taken control transfer this cycle
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (word aligned)
imem_gnt  in  1  request accepted
imem_rvalid  in  1  response data valid
imem_rdata  in  32  response instruction
if_valid  out  1  instruction available to decode
if_pc  out  32  PC of held instruction
if_inst  out  32  held instruction
if_ready  in  1  decode accepts
misalign_fault  out  1  sticky: redirect target not word aligned
state_dbg  out  2  current FSM state encoding

Behaviour:
- Redirect takes effect only when redirect_valid=1 and npc_op!=000. With npc_op=000, redirect_valid is ignored; sequential PC is fetch_pc+4, computed internally with 32-bit wrap (FFFF_FFFC -> 0000_0000).
- Undefined npc_op values (011, 101, 110, 111) with redirect_valid=1 are treated as JALR: use npc_target.
- FSM states:
  - S_FETCH (00): imem_req=1, imem_addr=fetch_pc. On gnt, go to S_WAIT.
  - S_WAIT (01): wait for rvalid. On rvalid, capture imem_rdata and pc into the hold buffer, then go to S_HOLD.
  - S_HOLD (10): if_valid=1. When if_valid&if_ready, fetch_pc<=fetch_pc+4 and go to S_FETCH.
  - S_HALT (11): terminal. imem_req=0, if_valid=0.
- Single outstanding request; imem_req is never asserted in S_WAIT, S_HOLD or S_HALT.
- Minimum 3 cycles per instruction: gnt in cycle t, rvalid at t+1, if_valid at t+2.
- imem_req/imem_addr stay stable until gnt.
- Redirect with aligned target (target[1:0]==00): fetch_pc<=npc_target on the next edge, and the fetch state is flushed per state:
  - S_FETCH without gnt: stay in S_FETCH with the new address next cycle.
  - S_FETCH with gnt in the same cycle: go to S_WAIT with drop=1.
  - S_WAIT without rvalid: set drop=1 and stay in S_WAIT.
  - S_WAIT with rvalid in the same cycle: discard the response, go to S_FETCH.
  - S_HOLD: clear the buffer (if_valid=0 next cycle), go to S_FETCH. If if_ready was high in the same cycle, the handshake still counts as completed, but the redirect target wins over +4.
- drop flag: in S_WAIT with drop=1, rvalid is consumed without capture, then go to S_FETCH and clear drop.
- Redirect with misaligned target: misalign_fault<=1 (sticky), any buffered instruction is flushed, and go to S_HALT once no response is outstanding. If drop is pending, wait for rvalid first.
- Redirect while in S_HALT is ignored.
- Reset values:
  - FSM state: S_FETCH.
  - fetch_pc: RESET_PC. npc_pc mirrors fetch_pc; imem_addr is the same value.
  - imem_req=0 during the reset cycle, then 1.
  - if_valid=0, if_pc=0, if_inst=NOP_INST.
  - drop=0, misalign_fault=0.
- Reset mid-transaction: an outstanding response arriving after reset is ignored, because drop is cleared and the FSM is in S_FETCH.
  - Known limitation, and a requirement on the memory side: the memory must not deliver an rvalid for a pre-reset request after reset is released.
- if_pc/if_inst hold their value while if_valid=0; they return to NOP_INST/0 only on reset.

Decomposition:
- Shared package fetch_pkg holds:
  - NPC op codes: NPC_PLUS4 000, NPC_BRANCH 001, NPC_JAL 010, NPC_JALR 100.
  - FSM state encodings, which also drive state_dbg.
  - NOP_INST.
- One sub-module, fetch_hold_buf: the pc/inst capture register with load, clear and valid flag, driven by the FSM.

Test Plan:
- Reset release, memory with 0-cycle gnt and 1-cycle rvalid, if_ready=1. Required: imem_addr sequence 0,4,8; if_valid every 3rd cycle; if_pc matches; if_inst equals imem_rdata.
- Stall: hold if_ready=0 for 5 cycles in S_HOLD. Required: if_valid held, if_inst stable, imem_req=0; one accept, then exactly one new fetch of pc+4.
- JAL redirect (op 010, target 0x100) in S_WAIT, rvalid 2 cycles later. Required: that response dropped, never visible on if_valid; next imem_addr=0x100.
- Redirect (op 001, target 0x40) coincident with gnt, then redirect_valid with op 000. Required: dropped response; next fetch 0x40; op-000 pulse has no effect.
- JALR redirect to 0x102. Required: misalign_fault=1 next cycle, state_dbg=11, imem_req stays 0 until rst; rst clears the fault and fetch resumes at RESET_PC.
- Wrap: RESET_PC=0xFFFF_FFFC. Required: second fetch address is 0x0000_0000.
